// File: rtl/intersection_controller.sv
// Four-way intersection sequencer: half-second time base, phase FSM with
// NS advanced-left and pedestrian walk windows, and light-code decode.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ALLRED_A | all-red clearance before NS; chooses NS_LEFT or NS_GREEN
// NS_LEFT  | NS advanced-left arrow, EW red
// NS_GREEN | NS through green; NS-parallel walk window if granted
// NS_AMBER | NS amber, EW red
// ALLRED_B | all-red clearance before EW
// EW_GREEN | EW through green; EW-parallel walk window if granted
// EW_AMBER | EW amber, NS red
module intersection_controller #(
    parameter int HALF_SEC_CYCLES = 25_000_000,
    parameter int GREEN_T         = 20,
    parameter int AMBER_T         = 6,
    parameter int ALLRED_T        = 2,
    parameter int LEFT_T          = 8,
    parameter int WALK_T          = 10,
    parameter int FLASH_T         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       leftRequest,
    input  logic       pedRequest,
    output logic       halfSec,
    output logic [2:0] nsLight,
    output logic [2:0] ewLight,
    output logic [2:0] nsWalk,
    output logic [2:0] ewWalk
);

    localparam int DIV_W = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_SEC_CYCLES - 1);

    localparam int MAX_GA  = (GREEN_T > AMBER_T) ? GREEN_T : AMBER_T;
    localparam int MAX_RL  = (ALLRED_T > LEFT_T) ? ALLRED_T : LEFT_T;
    localparam int MAX_T   = (MAX_GA > MAX_RL) ? MAX_GA : MAX_RL;
    localparam int TMR_W   = $clog2(MAX_T + 1);

    localparam logic [TMR_W-1:0] GREEN_LAST  = TMR_W'(GREEN_T - 1);
    localparam logic [TMR_W-1:0] AMBER_LAST  = TMR_W'(AMBER_T - 1);
    localparam logic [TMR_W-1:0] ALLRED_LAST = TMR_W'(ALLRED_T - 1);
    localparam logic [TMR_W-1:0] LEFT_LAST   = TMR_W'(LEFT_T - 1);
    // Walk window edges lie inside the green phase, so they fit the timer width.
    localparam logic [TMR_W-1:0] WALK_END    = TMR_W'(WALK_T);
    localparam logic [TMR_W-1:0] FLASH_END   = TMR_W'(WALK_T + FLASH_T);

    localparam logic [2:0] CODE_GREEN = 3'b001;
    localparam logic [2:0] CODE_AMBER = 3'b010;
    localparam logic [2:0] CODE_RED   = 3'b100;
    localparam logic [2:0] CODE_LEFT  = 3'b101;
    localparam logic [2:0] CODE_WALK  = 3'b110;
    localparam logic [2:0] CODE_DONT  = 3'b011;
    localparam logic [2:0] CODE_FLASH = 3'b111;

    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        NS_LEFT  = 3'd1,
        NS_GREEN = 3'd2,
        NS_AMBER = 3'd3,
        ALLRED_B = 3'd4,
        EW_GREEN = 3'd5,
        EW_AMBER = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               half_sec_q, half_sec_d;
    logic               left_latch_q, left_latch_d;
    logic               ped_latch_q, ped_latch_d;
    logic               walk_grant_q, walk_grant_d;

    logic               tick;
    logic [TMR_W-1:0]   last_cnt;
    logic               phase_done;
    logic               enter_green;
    logic               enter_left;
    logic               leave_green;
    logic [2:0]         walk_code;

    // Free-running half-second divider and square-wave output.
    always_comb begin
        tick       = (div_q == DIV_LAST);
        div_d      = tick ? '0 : div_q + DIV_W'(1);
        half_sec_d = half_sec_q ^ tick;
    end

    // Terminal timer value of the current phase.
    always_comb begin
        last_cnt = ALLRED_LAST;
        case (state_q)
            ALLRED_A, ALLRED_B: last_cnt = ALLRED_LAST;
            NS_LEFT:            last_cnt = LEFT_LAST;
            NS_GREEN, EW_GREEN: last_cnt = GREEN_LAST;
            NS_AMBER, EW_AMBER: last_cnt = AMBER_LAST;
            default:            last_cnt = ALLRED_LAST;
        endcase
    end

    // Phase sequencing, phase timer and walk-window grant.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        walk_grant_d = walk_grant_q;
        phase_done   = tick && (timer_q == last_cnt);

        if (tick) begin
            timer_d = timer_q + TMR_W'(1);
        end

        if (phase_done) begin
            timer_d = '0;
            case (state_q)
                ALLRED_A: state_d = left_latch_q ? NS_LEFT : NS_GREEN;
                NS_LEFT:  state_d = NS_GREEN;
                NS_GREEN: state_d = NS_AMBER;
                NS_AMBER: state_d = ALLRED_B;
                ALLRED_B: state_d = EW_GREEN;
                EW_GREEN: state_d = EW_AMBER;
                EW_AMBER: state_d = ALLRED_A;
                default:  state_d = ALLRED_A;
            endcase
        end

        enter_green = phase_done && ((state_d == NS_GREEN) || (state_d == EW_GREEN));
        enter_left  = phase_done && (state_d == NS_LEFT);
        leave_green = phase_done && ((state_q == NS_GREEN) || (state_q == EW_GREEN));

        if (enter_green) begin
            walk_grant_d = ped_latch_q;
        end else if (leave_green) begin
            walk_grant_d = 1'b0;
        end

        // A request present on the consuming edge stays latched for next time.
        ped_latch_d  = pedRequest  | (ped_latch_q  & ~enter_green);
        left_latch_d = leftRequest | (left_latch_q & ~enter_left);
    end

    // State, timer, divider and latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ALLRED_A;
            div_q        <= '0;
            timer_q      <= '0;
            half_sec_q   <= 1'b0;
            left_latch_q <= 1'b0;
            ped_latch_q  <= 1'b0;
            walk_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            timer_q      <= timer_d;
            half_sec_q   <= half_sec_d;
            left_latch_q <= left_latch_d;
            ped_latch_q  <= ped_latch_d;
            walk_grant_q <= walk_grant_d;
        end
    end

    // Walk head code as a function of time spent in the green phase.
    always_comb begin
        walk_code = CODE_DONT;
        if (timer_q < WALK_END) begin
            walk_code = CODE_WALK;
        end else if (timer_q < FLASH_END) begin
            walk_code = CODE_FLASH;
        end
    end

    // Light-code decode from registered state.
    always_comb begin
        nsLight = CODE_RED;
        ewLight = CODE_RED;
        nsWalk  = CODE_DONT;
        ewWalk  = CODE_DONT;
        case (state_q)
            NS_LEFT:  nsLight = CODE_LEFT;
            NS_GREEN: begin
                nsLight = CODE_GREEN;
                if (walk_grant_q) nsWalk = walk_code;
            end
            NS_AMBER: nsLight = CODE_AMBER;
            EW_GREEN: begin
                ewLight = CODE_GREEN;
                if (walk_grant_q) ewWalk = walk_code;
            end
            EW_AMBER: ewLight = CODE_AMBER;
            default: begin
                nsLight = CODE_RED;
                ewLight = CODE_RED;
            end
        endcase
    end

    assign halfSec = half_sec_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller with a short time base: segment tables
// of expected light codes drive a per-cycle scoreboard, plus a hand-written
// mid-phase reset sequence.
module tb_intersection_controller;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] A = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] L = 3'b101;
    localparam logic [2:0] W = 3'b110;
    localparam logic [2:0] D = 3'b011;
    localparam logic [2:0] F = 3'b111;

    logic       clk;
    logic       reset;
    logic       leftRequest;
    logic       pedRequest;
    logic       halfSec;
    logic [2:0] nsLight, ewLight, nsWalk, ewWalk;

    intersection_controller #(
        .HALF_SEC_CYCLES(4), .GREEN_T(8), .AMBER_T(2), .ALLRED_T(1),
        .LEFT_T(3), .WALK_T(3), .FLASH_T(2)
    ) dut (
        .clk(clk), .reset(reset), .leftRequest(leftRequest), .pedRequest(pedRequest),
        .halfSec(halfSec), .nsLight(nsLight), .ewLight(ewLight),
        .nsWalk(nsWalk), .ewWalk(ewWalk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       left;
        logic       ped;
        logic [2:0] ns, ew, nsw, eww;
        int         n;
    } seg_t;

    typedef struct {
        logic [11:0] lights;
        logic        half;
        int          cyc;
    } exp_t;

    seg_t tbl[$];
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   j       = 0;

    function automatic bit legal(input logic [2:0] c);
        return (c == G) || (c == A) || (c == R) || (c == L) ||
               (c == W) || (c == D) || (c == F);
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, got, want);
    endtask

    task automatic add(input logic l, input logic p, input logic [2:0] ns, input logic [2:0] ew,
                       input logic [2:0] nsw, input logic [2:0] eww, input int n);
        seg_t s;
        s.left = l; s.ped = p; s.ns = ns; s.ew = ew; s.nsw = nsw; s.eww = eww; s.n = n;
        tbl.push_back(s);
    endtask

    // Push one expectation per driven cycle, then advance to the next cycle.
    task automatic run_table();
        exp_t e;
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                e.lights = {tbl[i].ns, tbl[i].ew, tbl[i].nsw, tbl[i].eww};
                e.half   = ((j / 4) % 2) == 1;
                e.cyc    = j;
                sb.push_back(e);
                leftRequest = tbl[i].left;
                pedRequest  = tbl[i].ped;
                @(posedge clk);
                #1;
                j++;
            end
        end
        leftRequest = 1'b0;
        pedRequest  = 1'b0;
        tbl.delete();
    endtask

    // Scoreboard: compare each cycle mid-period, plus legality and conflict checks.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if ({nsLight, ewLight, nsWalk, ewWalk, halfSec} === {e.lights, e.half}) begin
                n_pass++;
            end else begin
                $display("FAIL seq cyc=%0d: got ns=%b ew=%b nsw=%b eww=%b half=%b, expected ns=%b ew=%b nsw=%b eww=%b half=%b",
                         e.cyc, nsLight, ewLight, nsWalk, ewWalk, halfSec,
                         e.lights[11:9], e.lights[8:6], e.lights[5:3], e.lights[2:0], e.half);
            end
            n_total++;
            if (legal(nsLight) && legal(ewLight) && legal(nsWalk) && legal(ewWalk) &&
                !((nsLight != R) && (ewLight != R))) begin
                n_pass++;
            end else begin
                $display("FAIL legal cyc=%0d: got ns=%b ew=%b nsw=%b eww=%b, expected legal codes with a red head",
                         e.cyc, nsLight, ewLight, nsWalk, ewWalk);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        leftRequest = 1'b0;
        pedRequest  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {nsLight, ewLight, nsWalk, ewWalk, halfSec}, {R, R, D, D, 1'b0});
        reset = 1'b0;
        j     = 0;

        // Cycle 1: plain sequence, left pulse in EW green.
        add(0,0,R,R,D,D,4);  add(0,0,G,R,D,D,32); add(0,0,A,R,D,D,8);
        add(0,0,R,R,D,D,4);  add(1,0,R,G,D,D,1);  add(0,0,R,G,D,D,31);
        add(0,0,R,A,D,D,8);
        // Cycle 2: arrow served; ped pulse in NS amber gives EW walk window.
        add(0,0,R,R,D,D,4);  add(0,0,L,R,D,D,12); add(0,0,G,R,D,D,32);
        add(0,1,A,R,D,D,1);  add(0,0,A,R,D,D,7);  add(0,0,R,R,D,D,4);
        add(0,0,R,G,D,W,12); add(0,0,R,G,D,F,8);  add(0,0,R,G,D,D,12);
        add(0,0,R,A,D,D,8);
        // Cycle 3: no arrow; ped held across NS green entry -> both walk windows.
        add(0,0,R,R,D,D,2);  add(0,1,R,R,D,D,2);
        add(0,0,G,R,W,D,12); add(0,0,G,R,F,D,8);  add(0,0,G,R,D,D,12);
        add(0,0,A,R,D,D,8);  add(0,0,R,R,D,D,4);
        add(0,0,R,G,D,W,12); add(0,0,R,G,D,F,8);  add(0,0,R,G,D,D,12);
        add(0,0,R,A,D,D,8);
        // Cycle 4: no walk; both latches set in EW green before reset.
        add(0,0,R,R,D,D,4);  add(0,0,G,R,D,D,32); add(0,0,A,R,D,D,8);
        add(0,0,R,R,D,D,4);  add(1,1,R,G,D,D,1);  add(0,0,R,G,D,D,10);
        run_table();

        // Asynchronous reset mid-cycle while halfSec is high.
        check("pre_reset_half", {12'd0, halfSec}, 13'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {nsLight, ewLight, nsWalk, ewWalk, halfSec}, {R, R, D, D, 1'b0});
        @(posedge clk);
        #1;
        check("reset_hold", {nsLight, ewLight, nsWalk, ewWalk, halfSec}, {R, R, D, D, 1'b0});
        reset = 1'b0;
        j     = 0;

        // After reset: latches gone, so no arrow and no walk.
        add(0,0,R,R,D,D,4);  add(0,0,G,R,D,D,32); add(0,0,A,R,D,D,8);
        add(0,0,R,R,D,D,4);  add(0,0,R,G,D,D,8);
        run_table();

        @(negedge clk);
        #1;
        check("scoreboard_drained", {12'd0, sb.size() == 0}, 13'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
